iomem_timer: RTL
================

// Module: iomem_timer
// PURPOSE
//  Memory-mapped 32-bit down-counting timer on the SoC iomem bus, downstream of the CPU's iomem port.
//  It decodes its own address window, acknowledges accesses with one wait state, and counts prescaled clock ticks.
//  It raises a level interrupt on expiry. Typical uses are software delays and periodic ticks for firmware.
// PARAMETERS
//  BASE_ADDR   32'h0300_0000  window base; window = BASE_ADDR .. BASE_ADDR+0xFF
//  PRESC_W     16             prescaler register width (bits)
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   reset, synchronous, active-low
//  iomem_valid  in   1   bus request from CPU
//  iomem_ready  out  1   one-cycle acknowledge
//  iomem_wstrb  in   4   byte write strobes; 0 = read
//  iomem_addr   in   32  byte address
//  iomem_wdata  in   32  write data
//  iomem_rdata  out  32  read data, valid while iomem_ready=1, else 0
//  irq          out  1   level interrupt = STATUS.expired & CTRL.irq_en
// BEHAVIOUR
//  Register map (offset, byte lanes honoured per wstrb):
//   0x00 CTRL   [0] en, [1] autoreload, [2] irq_en; other bits read 0
//   0x04 PRESC  [PRESC_W-1:0]; one tick every PRESC+1 clocks
//   0x08 LOAD   32-bit reload value
//   0x0C COUNT  32-bit current count, read/write
//   0x10 STATUS [0] expired, write-1-to-clear
//   other offsets in window: read 0, writes ignored, still acknowledged
//  Reset: all registers 0, prescaler count 0, iomem_ready=0, iomem_rdata=0, irq=0.
//  Handshake:
//   - sel = iomem_valid & addr[31:8]==BASE_ADDR[31:8]
//   - accept edge = rising edge with sel & !iomem_ready
//   - at the accept edge: writes are applied, rdata is registered, and iomem_ready is set for exactly one cycle (latency 1)
//   - iomem_ready is forced to 0 on the cycle after a pulse, even if valid is still high; no back-to-back ack
//   - addresses outside the window get no response; ready and rdata stay 0
//  Prescaler:
//   - pcnt counts while CTRL.en=1
//   - tick asserts when pcnt==PRESC, then pcnt returns to 0
//   - PRESC=0 gives a tick every clock
//   - writing PRESC or clearing en resets pcnt to 0
//  Counter, evaluated on tick:
//   - COUNT!=0: COUNT-1
//   - COUNT==0: set expired; if autoreload, COUNT<=LOAD, else CTRL.en<=0 (one-shot stop)
//   - LOAD=0 with autoreload: expires on every tick
//  Simultaneous events:
//   - a bus write to COUNT beats the tick update in the same cycle
//   - a hardware set of expired beats a W1C clear in the same cycle
//   - a write to CTRL.en beats the one-shot auto-clear
//  A reset assertion mid-transaction drops iomem_ready the next edge; the transaction is lost and the CPU is reset with it.
//  irq is combinational from registered state and has no glitch path from the bus.
// STRUCTURE
//  Package iomem_timer_pkg: register offset localparams (OFS_CTRL..OFS_STATUS), CTRL bit indices, STATUS_EXPIRED index.
//  Sub-module timer_prescaler (clk, resetn, en, clr, presc, tick) holds the PRESC_W counter.
//  Top level holds the bus decode/ack FSM (IDLE, ACK), the register file and the count datapath.
// TESTING
//  1. Reset, read all 5 regs -> 0; ready exactly 1 cycle after valid; irq=0.
//  2. Write LOAD=3, PRESC=0, CTRL=0x7 -> COUNT 3,2,1,0 over 3 clks, expired and irq=1 at tick 4, COUNT reload 3; period 4 clks.
//  3. Write LOAD=5, PRESC=1, CTRL=0x1 (one-shot), COUNT=5 -> expires after 12 clks; CTRL.en reads 0; COUNT holds 0.
//  4. Expired=1, write STATUS=1 on the same cycle as a new expiry -> expired stays 1; W1C alone -> 0, irq drops next cycle.
//  5. Write COUNT=0x100 on a tick cycle -> COUNT reads 0x100, not 0xFF; wstrb=0x1 on LOAD=0xFFFFFFFF, data 0 -> 0xFFFFFF00.
//  6. Access 0x0300_0020 -> ack, rdata 0; access 0x0400_0000 -> no ready for 10 cycles; hold valid high through ack -> ready pulses exactly once.

Source files
------------

// File: rtl/iomem_timer_pkg.sv
// iomem_timer_pkg
//   Shared definitions for the iomem timer: register offsets inside the
//   256-byte window, CTRL/STATUS bit positions, the bus FSM state type and a
//   byte-lane merge helper used for partial (wstrb) writes.
package iomem_timer_pkg;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_PRESC  = 8'h04;
  localparam logic [7:0] OFS_LOAD   = 8'h08;
  localparam logic [7:0] OFS_COUNT  = 8'h0C;
  localparam logic [7:0] OFS_STATUS = 8'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_W          = 3;

  localparam int STATUS_EXPIRED  = 0;

  // IDLE: waiting for a selected request; ACK: ready is high this cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  // Replace the bytes of old_v whose strobe is set with the bytes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// iomem_timer_if
//   CPU iomem bus bundle.
//   Handshake: the master raises iomem_valid with addr/wstrb/wdata stable and
//   keeps them stable until it sees iomem_ready=1 for one cycle; the slave
//   returns iomem_ready for exactly one cycle per accepted request and
//   iomem_rdata is meaningful only in that cycle (0 otherwise). wstrb=0 is a
//   read. Ready is never asserted on two consecutive cycles.
//   modport master : CPU side (drives valid/wstrb/addr/wdata)
//   modport slave  : peripheral side (drives ready/rdata)
interface iomem_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler
//   Divides the clock into ticks: with en=1, tick is high on one cycle out of
//   every presc+1. The counter is held at 0 while disabled or when clr is
//   pulsed (a PRESC write), so a fresh configuration always starts a full
//   period.
//   clk, resetn : clock, synchronous active-low reset
//   en          : count enable
//   clr         : restart the period (counter back to 0)
//   presc       : period minus one
//   tick        : one-cycle tick output (combinational from the counter)
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == presc);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (tick) pcnt_d = '0;
    if (!en || clr) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/iomem_timer.sv
// iomem_timer
//   Memory-mapped 32-bit down-counting timer on the iomem bus. Decodes the
//   window BASE_ADDR..BASE_ADDR+0xFF, acknowledges with one wait state and
//   decrements COUNT once per prescaler tick; STATUS.expired is raised when a
//   tick finds COUNT at 0 and drives a level interrupt when CTRL.irq_en=1.
//   clk, resetn  : clock, synchronous active-low reset
//   bus          : iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//   irq          : STATUS.expired & CTRL.irq_en, from registers only
//   dbg_state_o  : bus FSM state for observation
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  iomem_timer_if.slave     bus,
  output logic             irq,
  output bus_state_t       dbg_state_o
);

  bus_state_t state_q, state_d;

  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               expired_q, expired_d;
  logic [31:0]        rdata_q, rdata_d;

  logic        sel;
  logic        accept;
  logic        wr;
  logic [7:0]  ofs;
  logic [31:0] rd_val;
  logic [31:0] wmerge;
  logic        wr_ctrl, wr_presc, wr_load, wr_count, wr_status;
  logic        tick;
  logic        expire;

  assign ofs = bus.iomem_addr[7:0];
  assign sel = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr  = accept && (bus.iomem_wstrb != 4'b0000);

  assign wr_ctrl   = wr && (ofs == OFS_CTRL);
  assign wr_presc  = wr && (ofs == OFS_PRESC);
  assign wr_load   = wr && (ofs == OFS_LOAD);
  assign wr_count  = wr && (ofs == OFS_COUNT);
  assign wr_status = wr && (ofs == OFS_STATUS);

  // Bus FSM: a request is accepted only from IDLE, so the ACK cycle always
  // returns to IDLE and ready can never be high two cycles in a row.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          accept  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux over current register state; also the base for byte merges.
  always_comb begin
    rd_val = 32'h0;
    case (ofs)
      OFS_CTRL:   rd_val = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFS_PRESC:  rd_val = {{(32-PRESC_W){1'b0}}, presc_q};
      OFS_LOAD:   rd_val = load_q;
      OFS_COUNT:  rd_val = count_q;
      OFS_STATUS: rd_val = 32'(expired_q) << STATUS_EXPIRED;
      default:    rd_val = 32'h0;
    endcase
  end

  assign wmerge = merge_bytes(rd_val, bus.iomem_wdata, bus.iomem_wstrb);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .resetn (resetn),
    .en     (ctrl_q[CTRL_EN]),
    .clr    (wr_presc),
    .presc  (presc_q),
    .tick   (tick)
  );

  assign expire = tick && (count_q == 32'h0);

  // Register file and count datapath. Later assignments win, which encodes
  // the same-cycle priorities: bus COUNT write over the tick update, bus
  // CTRL.en write over the one-shot stop, hardware expiry over W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    rdata_d   = accept ? rd_val : 32'h0;

    if (tick) begin
      if (count_q != 32'h0)            count_d = count_q - 32'h1;
      else if (ctrl_q[CTRL_AUTORELOAD]) count_d = load_q;
    end
    if (expire && !ctrl_q[CTRL_AUTORELOAD]) ctrl_d[CTRL_EN] = 1'b0;

    // Only byte lane 0 carries CTRL bits, so only that strobe writes CTRL.
    if (wr_ctrl && bus.iomem_wstrb[0]) ctrl_d = wmerge[CTRL_W-1:0];
    if (wr_presc) presc_d = wmerge[PRESC_W-1:0];
    if (wr_load)  load_d  = wmerge;
    if (wr_count) count_d = wmerge;

    if (wr_status && bus.iomem_wstrb[0] && bus.iomem_wdata[STATUS_EXPIRED])
      expired_d = 1'b0;
    if (expire) expired_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      presc_q   <= '0;
      load_q    <= 32'h0;
      count_q   <= 32'h0;
      expired_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.iomem_ready = (state_q == ST_ACK);
  assign bus.iomem_rdata = rdata_q;
  assign irq             = expired_q & ctrl_q[CTRL_IRQ_EN];
  assign dbg_state_o     = state_q;

endmodule
